// File: rtl/data_stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among NUM_REQ masters.
// Grants are held for up to MAX_BURST beats; the output is a single register slice.
module data_stream_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      s_data,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  s_strb,
    input  logic [NUM_REQ-1:0]                 s_valid,
    output logic [NUM_REQ-1:0]                 s_ready,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic [DATA_WIDTH/8-1:0]            m_strb,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [NUM_REQ-1:0]                 grant
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IdxW       = $clog2(NUM_REQ);
    localparam int unsigned CntW       = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IdxW-1:0]         last_idx_q, last_idx_d;
    logic [CntW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [STRB_WIDTH-1:0]   m_strb_q, m_strb_d;
    logic                    m_valid_q, m_valid_d;

    logic                    stage_free;
    logic [IdxW-1:0]         win_idx;
    logic                    found;
    int unsigned             cand;

    assign stage_free = !m_valid_q || m_ready;

    // First requesting index after the last winner, wrapping at NUM_REQ.
    always_comb begin
        win_idx = last_idx_q;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (last_idx_q + k) % NUM_REQ;
            if (!found && s_valid[cand[IdxW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        beat_cnt_d = beat_cnt_q;
        m_data_d   = m_data_q;
        m_strb_d   = m_strb_q;
        m_valid_d  = m_valid_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (|s_valid) begin
                    state_d    = StBurst;
                    grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    last_idx_d = win_idx;
                    beat_cnt_d = '0;
                end
            end
            StBurst: begin
                // Under backpressure the grant is held regardless of s_valid.
                if (stage_free) begin
                    if (s_valid[last_idx_q]) begin
                        m_data_d   = s_data[last_idx_q*DATA_WIDTH +: DATA_WIDTH];
                        m_strb_d   = s_strb[last_idx_q*STRB_WIDTH +: STRB_WIDTH];
                        m_valid_d  = 1'b1;
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                        if (beat_cnt_q == CntW'(MAX_BURST - 1)) begin
                            state_d = StIdle;
                            grant_d = '0;
                        end
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            last_idx_q <= IdxW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            m_data_q   <= '0;
            m_strb_q   <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            beat_cnt_q <= beat_cnt_d;
            m_data_q   <= m_data_d;
            m_strb_q   <= m_strb_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign s_ready = (state_q == StBurst && stage_free) ? grant_q : '0;
    assign grant   = grant_q;
    assign m_data  = m_data_q;
    assign m_strb  = m_strb_q;
    assign m_valid = m_valid_q;

endmodule

// File: doc/data_stream_rr_arbiter.md
# data_stream_rr_arbiter

Round-robin arbiter that shares one downstream valid/ready data stream (data, strb, valid, ready) among NUM_REQ upstream masters. Each grant is held for a burst of up to MAX_BURST beats, or until the granted source goes idle. The output is one registered pipeline stage that carries full throughput. It sits between several producer engines and a single consumer such as a shared AXI write datapath or a CDC FIFO.

## Interface
- NUM_REQ, 4: number of upstream requesters, ≥2.
- DATA_WIDTH, 32: stream data width, multiple of 8.
- MAX_BURST, 8: maximum beats per grant before forced re-arbitration, ≥1.
- STRB_WIDTH (localparam), DATA_WIDTH/8.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous assert, active-high.
- s_data  in  NUM_REQ*DATA_WIDTH  packed requester data; requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_strb  in  NUM_REQ*STRB_WIDTH  packed requester strobes, same slicing.
- s_valid  in  NUM_REQ  per-requester valid.
- s_ready  out  NUM_REQ  per-requester ready; at most one bit set.
- m_data  out  DATA_WIDTH  downstream data (registered).
- m_strb  out  STRB_WIDTH  downstream strobe (registered).
- m_valid  out  1  downstream valid (registered).
- m_ready  in  1  downstream ready.
- grant  out  NUM_REQ  one-hot current grant, all-zero in IDLE (registered).

## Operation
- FSM states: IDLE, BURST.
- Internal registers: last_idx (index of the last granted requester) and beat_cnt (width $clog2(MAX_BURST)+1).
- IDLE:
  - If any s_valid is set, select the first set bit searching cyclically from last_idx+1, wrapping at NUM_REQ.
  - Register grant, set last_idx to the winner, clear beat_cnt, go to BURST.
  - If no s_valid is set, stay in IDLE. grant stays 0.
- Output stage accept condition: stage_free = !m_valid || m_ready.
- BURST, granted index g:
  - s_ready[g] = stage_free. All other s_ready bits are 0. s_ready is combinational from state and the output stage.
  - Input beat accepted when s_valid[g] && s_ready[g]. On acceptance:
    - load m_data and m_strb from slice g;
    - set m_valid;
    - increment beat_cnt.
  - If an accepted beat has beat_cnt == MAX_BURST-1, go to IDLE and clear grant.
  - If stage_free && !s_valid[g], the source is idle: go to IDLE and clear grant. No beat is taken.
  - If !stage_free, stay in BURST whatever s_valid[g] is. The grant is not released while the consumer backpressures.
- Output stage, every cycle:
  - m_ready && m_valid with no new input beat: clear m_valid.
  - Simultaneous output drain and input accept: m_valid stays 1 and the data is replaced.
  - m_data and m_strb hold their value while m_valid && !m_ready.
- The block never drops, duplicates or reorders beats from one requester. Strobes pass through unmodified.
- Reset (any time, including mid-burst or with a beat held in the stage):
  - state IDLE, grant 0, s_ready 0;
  - m_valid 0, m_data 0, m_strb 0;
  - beat_cnt 0, last_idx NUM_REQ-1, so requester 0 has first priority;
  - any held beat is discarded.

## Timing
- Arbitration latency: s_valid[i] rises in cycle 0 while in IDLE → grant[i] and s_ready[i] high in cycle 1 → first beat on m_valid in cycle 2 (with m_ready=1).
- Throughput within a burst: 1 beat/cycle when m_ready is held high.
- Re-arbitration cost: one IDLE cycle between bursts, so NUM_REQ saturated requesters give MAX_BURST beats per MAX_BURST+1 cycles.
- MAX_BURST=1 gives per-beat round robin at 50 % throughput.
- Released requester: its s_ready drops the cycle after its last accepted beat.
- The downstream stream holds valid-ready rules: m_valid, once high, is not cleared before m_ready, and m_data is stable while stalled.

## Test plan
- Single requester, MAX_BURST=8, s_valid[2] high for 20 beats (data 0..19), m_ready=1:
  - m_valid first at cycle 2;
  - m_data 0..19 in order;
  - one bubble after beats 7 and 15;
  - grant=4'b0100 every time.
- All four requesters saturated, MAX_BURST=4: grant order 0,1,2,3,0, with 4 beats per grant and 1 IDLE cycle between grants. Totals after 50 cycles differ by ≤4 beats between requesters.
- Backpressure: m_ready toggled 1,0,0,1 during a burst.
  - m_data is stable for all stalled cycles.
  - s_ready[g] is 0 whenever m_valid && !m_ready.
  - No beat is lost; sequence checked against a scoreboard.
- Early release: requester 1 sends 3 beats then drops s_valid while requester 3 waits.
  - State returns to IDLE the cycle after the drop is seen.
  - grant becomes 4'b1000 one cycle later; beat_cnt restarts.
- Reset mid-burst, with m_valid=1 and m_ready=0:
  - m_valid, grant and s_ready go 0 asynchronously;
  - after release with all s_valid high, requester 0 is granted first.
- Wrap-around priority: last_idx=3, s_valid=4'b1010 → requester 1 is granted, not 3.
